// File: rtl/fb_pattern_pkg.sv
// Shared encodings and default geometry for the frame-buffer pattern writer.
// Optional feature macro used by this slice: FB_PATTERN_BORDER_EN.
package fb_pattern_pkg;

   typedef enum logic [1:0] {
      PAT_SOLID   = 2'd0,
      PAT_LBAR    = 2'd1,
      PAT_CHECKER = 2'd2,
      PAT_GRID    = 2'd3
   } pat_mode_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_DONE = 2'd2
   } fb_state_e;

   localparam int DEF_H_RES     = 800;
   localparam int DEF_V_RES     = 480;
   localparam int DEF_WORD_W    = 16;
   localparam int DEF_ADDR_W    = 16;
   localparam int DEF_CELL_LOG2 = 4;

   // Counter width that stays legal when a dimension collapses to one entry.
   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fb_pattern_word.sv
// Combinational builder of one packed 1-bpp word from (mode, word column, line).
// FB_PATTERN_BORDER_EN adds a 1-pixel white frame around the whole image.
module fb_pattern_word
   import fb_pattern_pkg::*;
#(
   parameter int WORD_W    = DEF_WORD_W,
   parameter int CELL_LOG2 = DEF_CELL_LOG2,
   parameter int XW_W      = 6,
   parameter int Y_W       = 9
`ifdef FB_PATTERN_BORDER_EN
   ,
   parameter int H_RES     = DEF_H_RES,
   parameter int V_RES     = DEF_V_RES
`endif
) (
   input  logic [1:0]        i_mode,
   input  logic [XW_W-1:0]   i_xw,
   input  logic [Y_W-1:0]    i_y,
   output logic [WORD_W-1:0] o_word
);

   localparam int unsigned CELL_MASK = (32'd1 << CELL_LOG2) - 32'd1;

   int unsigned       w_px;
   int unsigned       w_py;
   logic              w_pix;
   logic [WORD_W-1:0] w_word;

   always_comb begin
      w_word = '0;
      w_px   = 0;
      w_pix  = 1'b0;
      w_py   = 32'(i_y);
      // i = 0 is the leftmost pixel and lands in the MSB.
      for (int i = 0; i < WORD_W; i++) begin
         w_px = i_xw * WORD_W + i;
         case (pat_mode_e'(i_mode))
            PAT_SOLID:   w_pix = 1'b1;
            PAT_LBAR:    w_pix = (i_xw == '0);
            PAT_CHECKER: w_pix = (((w_px >> CELL_LOG2) ^ (w_py >> CELL_LOG2)) & 32'd1) == 32'd0;
            PAT_GRID:    w_pix = ((w_px & CELL_MASK) == 32'd0) || ((w_py & CELL_MASK) == 32'd0);
            default:     w_pix = 1'b0;
         endcase
`ifdef FB_PATTERN_BORDER_EN
         w_pix = w_pix | (w_px == 32'd0) | (w_px == 32'(H_RES - 1))
                       | (w_py == 32'd0) | (w_py == 32'(V_RES - 1));
`endif
         w_word[WORD_W-1-i] = w_pix;
      end
   end

   assign o_word = w_word;

endmodule

// File: rtl/fb_pattern_writer.sv
// Fills a word-packed 1-bpp frame buffer with a selectable test pattern, one word per handshake.
// Optional white border when FB_PATTERN_BORDER_EN is defined (handled in fb_pattern_word).
module fb_pattern_writer
   import fb_pattern_pkg::*;
#(
   parameter int H_RES     = DEF_H_RES,
   parameter int V_RES     = DEF_V_RES,
   parameter int WORD_W    = DEF_WORD_W,
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int CELL_LOG2 = DEF_CELL_LOG2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [1:0]        mode,
   input  logic              wr_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [WORD_W-1:0] wr_data,
   output logic              busy,
   output logic              done
);

   localparam int WPL  = H_RES / WORD_W;
   localparam int XW_W = clog2_min1(WPL);
   localparam int Y_W  = clog2_min1(V_RES);
   localparam logic [XW_W-1:0] XW_LAST = XW_W'(WPL - 1);
   localparam logic [Y_W-1:0]  Y_LAST  = Y_W'(V_RES - 1);

   fb_state_e         r_state, w_nxt_state;
   logic [1:0]        r_mode, w_nxt_mode;
   logic [XW_W-1:0]   r_xw, w_nxt_xw, w_step_xw, w_bld_xw;
   logic [Y_W-1:0]    r_y, w_nxt_y, w_step_y, w_bld_y;
   logic [ADDR_W-1:0] r_addr, w_nxt_addr;
   logic [WORD_W-1:0] r_data, w_nxt_data, w_word;
   logic              r_wr_en, w_nxt_wr_en;
   logic              r_busy, w_nxt_busy;
   logic              r_done, w_nxt_done;
   logic              w_bld_mode_sel;
   logic [1:0]        w_bld_mode;
   logic              w_hs, w_last;

   assign w_hs      = r_wr_en & wr_ready;
   assign w_last    = (r_xw == XW_LAST) && (r_y == Y_LAST);
   assign w_step_xw = (r_xw == XW_LAST) ? '0 : r_xw + 1'b1;
   assign w_step_y  = (r_xw == XW_LAST) ? r_y + 1'b1 : r_y;

   // In IDLE the builder prepares word 0 from the live mode so it is ready on the start edge;
   // while filling it looks one word ahead so the register loads on each handshake.
   assign w_bld_mode_sel = (r_state == ST_IDLE);
   assign w_bld_mode     = w_bld_mode_sel ? mode : r_mode;
   assign w_bld_xw       = w_bld_mode_sel ? '0 : w_step_xw;
   assign w_bld_y        = w_bld_mode_sel ? '0 : w_step_y;

   fb_pattern_word #(
      .WORD_W    (WORD_W),
      .CELL_LOG2 (CELL_LOG2),
      .XW_W      (XW_W),
      .Y_W       (Y_W)
`ifdef FB_PATTERN_BORDER_EN
      ,
      .H_RES     (H_RES),
      .V_RES     (V_RES)
`endif
   ) u_word (
      .i_mode (w_bld_mode),
      .i_xw   (w_bld_xw),
      .i_y    (w_bld_y),
      .o_word (w_word)
   );

   always_comb begin
      w_nxt_state = r_state;
      w_nxt_mode  = r_mode;
      w_nxt_xw    = r_xw;
      w_nxt_y     = r_y;
      w_nxt_addr  = r_addr;
      w_nxt_data  = r_data;
      w_nxt_wr_en = r_wr_en;
      w_nxt_busy  = r_busy;
      w_nxt_done  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_nxt_state = ST_FILL;
               w_nxt_mode  = mode;
               w_nxt_xw    = '0;
               w_nxt_y     = '0;
               w_nxt_addr  = '0;
               w_nxt_data  = w_word;
               w_nxt_wr_en = 1'b1;
               w_nxt_busy  = 1'b1;
            end
         end
         ST_FILL: begin
            if (w_hs) begin
               if (w_last) begin
                  w_nxt_state = ST_DONE;
                  w_nxt_wr_en = 1'b0;
                  w_nxt_busy  = 1'b0;
                  w_nxt_done  = 1'b1;
               end else begin
                  w_nxt_xw   = w_step_xw;
                  w_nxt_y    = w_step_y;
                  w_nxt_addr = r_addr + 1'b1;
                  w_nxt_data = w_word;
               end
            end
         end
         ST_DONE: w_nxt_state = ST_IDLE;
         default: w_nxt_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_mode  <= 2'd0;
         r_xw    <= '0;
         r_y     <= '0;
         r_addr  <= '0;
         r_data  <= '0;
         r_wr_en <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_nxt_state;
         r_mode  <= w_nxt_mode;
         r_xw    <= w_nxt_xw;
         r_y     <= w_nxt_y;
         r_addr  <= w_nxt_addr;
         r_data  <= w_nxt_data;
         r_wr_en <= w_nxt_wr_en;
         r_busy  <= w_nxt_busy;
         r_done  <= w_nxt_done;
      end
   end

   assign wr_en   = r_wr_en;
   assign wr_addr = r_addr;
   assign wr_data = r_data;
   assign busy    = r_busy;
   assign done    = r_done;

endmodule

// File: tb/tb_fb_pattern_writer.sv
// Randomised bench for fb_pattern_writer with a per-cycle reference model of the fill.
// Literal expectations follow FB_PATTERN_BORDER_EN when it is defined for the build.
module tb_fb_pattern_writer;

   localparam int H_RES     = 800;
   localparam int V_RES     = 480;
   localparam int WORD_W    = 16;
   localparam int ADDR_W    = 16;
   localparam int CELL_LOG2 = 4;
   localparam int CELL      = 1 << CELL_LOG2;
   localparam int WPL       = H_RES / WORD_W;
   localparam int TOTAL     = WPL * V_RES;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic [1:0]        mode;
   logic              wr_ready;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [WORD_W-1:0] wr_data;
   logic              busy;
   logic              done;

   always #5 clk = ~clk;

   fb_pattern_writer #(
      .H_RES(H_RES), .V_RES(V_RES), .WORD_W(WORD_W), .ADDR_W(ADDR_W), .CELL_LOG2(CELL_LOG2)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .mode(mode), .wr_ready(wr_ready),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Picture defined pixel by pixel from the linear word address.
   function automatic logic [WORD_W-1:0] model_word(input int m, input int addr);
      logic [WORD_W-1:0] w;
      int y, xw, x;
      bit p;
      w  = '0;
      y  = addr / WPL;
      xw = addr % WPL;
      for (int i = 0; i < WORD_W; i++) begin
         x = xw * WORD_W + i;
         case (m)
            0:       p = 1'b1;
            1:       p = (xw == 0);
            2:       p = (((x / CELL) + (y / CELL)) % 2) == 0;
            default: p = ((x % CELL) == 0) || ((y % CELL) == 0);
         endcase
`ifdef FB_PATTERN_BORDER_EN
         if (x == 0 || x == H_RES - 1 || y == 0 || y == V_RES - 1) p = 1'b1;
`endif
         w[WORD_W-1-i] = p;
      end
      return w;
   endfunction

   // Reference model state, advanced at every falling edge.
   bit                mon_en = 1'b0;
   int                m_phase = 0;
   int                m_addr = 0;
   int                m_mode = 0;
   bit                m_clean = 1'b1;
   bit                m_stall = 1'b0;
   logic [ADDR_W-1:0] s_addr;
   logic [WORD_W-1:0] s_data;
   int                hs_cnt = 0;
   logic [WORD_W-1:0] cap [TOTAL];

   always @(negedge clk) begin
      if (mon_en) begin
         case (m_phase)
            1: begin
               chk("fill_wr_en", wr_en, 1);
               chk("fill_busy", busy, 1);
               chk("fill_done", done, 0);
               chk("fill_addr", wr_addr, m_addr);
               chk("fill_data", wr_data, model_word(m_mode, m_addr));
               if (m_stall) begin
                  chk("stall_addr", wr_addr, s_addr);
                  chk("stall_data", wr_data, s_data);
               end
            end
            2: begin
               chk("done_wr_en", wr_en, 0);
               chk("done_busy", busy, 0);
               chk("done_pulse", done, 1);
            end
            default: begin
               chk("idle_wr_en", wr_en, 0);
               chk("idle_busy", busy, 0);
               chk("idle_done", done, 0);
               if (m_clean) begin
                  chk("idle_addr", wr_addr, 0);
                  chk("idle_data", wr_data, 0);
               end
            end
         endcase
         if (wr_en && wr_ready) begin
            hs_cnt++;
            if (int'(wr_addr) < TOTAL) cap[int'(wr_addr)] = wr_data;
         end
         m_stall = 1'b0;
         if (reset) begin
            m_phase = 0;
            m_clean = 1'b1;
         end else begin
            case (m_phase)
               0: if (start) begin
                  m_phase = 1;
                  m_addr  = 0;
                  m_mode  = int'(mode);
                  m_clean = 1'b0;
               end
               1: if (wr_ready) begin
                  if (m_addr == TOTAL - 1) m_phase = 2;
                  else m_addr++;
               end else begin
                  m_stall = 1'b1;
                  s_addr  = wr_addr;
                  s_data  = wr_data;
               end
               default: m_phase = 0;
            endcase
         end
      end
   end

   bit rand_rdy  = 1'b0;
   bit rand_mode = 1'b0;

   task automatic tick();
      @(posedge clk);
      #1;
      if (rand_rdy) wr_ready = ($urandom_range(0, 99) < 70);
      if (rand_mode) mode = 2'($urandom_range(0, 3));
   endtask

   task automatic clear_cap();
      for (int a = 0; a < TOTAL; a++) cap[a] = 'x;
   endtask

   task automatic run_fill(input int m, input bit rnd, input int pulse_at, output int cyc);
      clear_cap();
      hs_cnt   = 0;
      rand_rdy = rnd;
      wr_ready = 1'b1;
      mode     = 2'(m);
      start    = 1'b1;
      tick();
      start     = 1'b0;
      rand_mode = 1'b1;
      cyc       = 1;
      chk("first_wr_en", wr_en, 1);
      chk("first_addr", wr_addr, 0);
      while (!done && cyc < 3 * TOTAL) begin
         if (cyc == pulse_at) start = 1'b1;
         tick();
         start = 1'b0;
         cyc++;
      end
      rand_mode = 1'b0;
      rand_rdy  = 1'b0;
      chk("fill_completed", done, 1);
      chk("handshake_count", hs_cnt, TOTAL);
      tick();
      chk("busy_after", busy, 0);
      chk("done_one_cycle", done, 0);
   endtask

   initial begin
      #(95000 * 10);
      $display("FAIL watchdog: simulation exceeded time budget");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      int k;
      reset    = 1'b1;
      start    = 1'b0;
      mode     = 2'd0;
      wr_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      mon_en = 1'b1;
      @(negedge clk);
      chk("rst_wr_en", wr_en, 0);
      chk("rst_wr_addr", wr_addr, 0);
      chk("rst_wr_data", wr_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      tick();
      reset = 1'b0;
      tick();

      chk("model_chk0", model_word(2, 0), 16'hFFFF);
      chk("model_grid50", model_word(3, 50), 16'h8000);
      chk("model_lbar51", model_word(1, 51), 16'h0000);

      run_fill(0, 1'b0, -1, cyc);
      chk("solid_latency", cyc, TOTAL + 1);
      chk("solid_a0", cap[0], 16'hFFFF);
      chk("solid_last", cap[TOTAL-1], 16'hFFFF);

      run_fill(1, 1'b1, 5000, cyc);
      chk("lbar_a0", cap[0], 16'hFFFF);
      chk("lbar_a50", cap[50], 16'hFFFF);
      chk("lbar_a51", cap[51], 16'h0000);
      chk("lbar_a23950", cap[23950], 16'hFFFF);
`ifdef FB_PATTERN_BORDER_EN
      chk("lbar_a1", cap[1], 16'hFFFF);
      chk("lbar_a99", cap[99], 16'h0001);
      chk("lbar_a23999", cap[23999], 16'hFFFF);
`else
      chk("lbar_a1", cap[1], 16'h0000);
      chk("lbar_a99", cap[99], 16'h0000);
      chk("lbar_a23999", cap[23999], 16'h0000);
`endif

      // CHECKER with random backpressure, reset while word 1000 is presented.
      clear_cap();
      rand_rdy = 1'b1;
      mode     = 2'd2;
      start    = 1'b1;
      tick();
      start = 1'b0;
      k     = 0;
      while (!(wr_en && wr_addr == 16'd1000) && k < 5000) begin
         tick();
         k++;
      end
      chk("reach_1000", wr_addr, 1000);
      reset = 1'b1;
      tick();
      chk("rst_mid_wr_en", wr_en, 0);
      chk("rst_mid_addr", wr_addr, 0);
      chk("rst_mid_busy", busy, 0);
      start = 1'b1;
      tick();
      chk("rst_wins_busy", busy, 0);
      chk("rst_wins_wr_en", wr_en, 0);
      reset    = 1'b0;
      start    = 1'b0;
      rand_rdy = 1'b0;
      wr_ready = 1'b1;
      chk("chk_a0", cap[0], 16'hFFFF);
      chk("chk_a801", cap[801], 16'hFFFF);
`ifdef FB_PATTERN_BORDER_EN
      chk("chk_a1", cap[1], 16'hFFFF);
      chk("chk_a800", cap[800], 16'h8000);
`else
      chk("chk_a1", cap[1], 16'h0000);
      chk("chk_a800", cap[800], 16'h0000);
`endif
      tick();

      // GRID restarted after reset must begin again at address 0.
      clear_cap();
      mode  = 2'd3;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("restart_wr_en", wr_en, 1);
      chk("restart_addr", wr_addr, 0);
      k = 0;
      while (!(wr_en && wr_addr == 16'd900) && k < 2000) begin
         tick();
         k++;
      end
      chk("reach_900", wr_addr, 900);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("grid_rst_wr_en", wr_en, 0);
      chk("grid_a0", cap[0], 16'hFFFF);
      chk("grid_a49", cap[49], 16'hFFFF);
      chk("grid_a50", cap[50], 16'h8000);
      chk("grid_a800", cap[800], 16'hFFFF);

      repeat (4) tick();
      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/fb_pattern_writer.md
# fb_pattern_writer

Parametrised framebuffer pattern generator. It fills a 1-bpp, word-packed frame buffer with one of four test patterns, one word per accepted write. It sits between the control logic and the frame-buffer RAM write port, ahead of the VGA scan-out path. Compared with the fixed 800x480 generator it adds:

- configurable resolution and word width
- selectable pattern modes
- start/busy/done control
- write-port backpressure

## Interface

Parameters:
- `H_RES`, 800: active pixels per line; must be a multiple of `WORD_W`.
- `V_RES`, 480: active lines.
- `WORD_W`, 16: pixels per RAM word, one bit per pixel.
- `ADDR_W`, 16: RAM word-address width; must satisfy 2^`ADDR_W` >= (`H_RES`/`WORD_W`)*`V_RES`.
- `CELL_LOG2`, 4: checker/grid cell size is 2^`CELL_LOG2` pixels.

Ports:
- `clk`  in  1  system clock; sole clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a fill; honoured only in IDLE.
- `mode`  in  2  pattern select, sampled on an accepted `start`: 0 SOLID, 1 LBAR, 2 CHECKER, 3 GRID.
- `wr_ready`  in  1  RAM accepts the current write this cycle.
- `wr_en`  out  1  write request.
- `wr_addr`  out  `ADDR_W`  word address.
- `wr_data`  out  `WORD_W`  packed pixels; bit `WORD_W`-1 is the leftmost pixel.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle pulse after the last write is accepted.

## Operation

- WPL = `H_RES`/`WORD_W` words per line; total = WPL*`V_RES` (24000 at defaults). Address = y*WPL + xw.
- States and transitions:
  - IDLE -> FILL when `start`=1.
  - FILL -> DONE when the last word is handshaken.
  - DONE -> IDLE unconditionally after one cycle.
- Counters: word column xw (0..WPL-1), line y (0..`V_RES`-1) and linear address. All three advance only on handshake (`wr_en`&&`wr_ready`).
  - xw wraps to 0 and increments y.
  - The last word has xw=WPL-1 and y=`V_RES`-1.
- Pixel x = xw*`WORD_W`+i, where i=0 is the leftmost pixel. Pixel value per mode:
  - SOLID: 1.
  - LBAR: 1 iff xw==0, i.e. a left bar one word wide.
  - CHECKER: ~((x>>`CELL_LOG2`) ^ (y>>`CELL_LOG2`)) & 1, so the top-left cell is white.
  - GRID: 1 iff x mod 2^`CELL_LOG2`==0 or y mod 2^`CELL_LOG2`==0.
- Address arithmetic is unsigned `ADDR_W`; no wrap is reachable given the parameter constraint.
- Backpressure: while `wr_en`=1 and `wr_ready`=0, `wr_addr`/`wr_data` are held stable. No word is skipped or duplicated.
- Boundary conditions:
  - `start` during FILL or DONE: ignored; `mode` is not resampled.
  - `mode` changes mid-fill: no effect.
  - `reset` mid-fill: next edge returns to IDLE with all outputs at reset values; no further writes. A new `start` refills from address 0.
  - `start` and `reset` asserted together: `reset` wins.

## Timing

- Reset values: `wr_en`=0, `wr_addr`=0, `wr_data`=0, `busy`=0, `done`=0.
- All outputs are registered.
- `start` sampled at edge N drives `busy`=1, `wr_en`=1, `wr_addr`=0 and the first word after edge N.
- With `wr_ready` held high, throughput is one word per cycle. The last handshake occurs at edge N+total.
- The handshake at the last word moves the FSM to DONE: `wr_en`=0, `busy`=0, `done`=1 for one cycle, then IDLE.
- Earliest re-start: `start` in the cycle after `done`.

## Configuration

- `FB_PATTERN_BORDER_EN` defined: a 1-pixel white border is ORed into every mode, covering x=0, x=`H_RES`-1, y=0 and y=`V_RES`-1.
- Undefined: the pattern is output unmodified, and no border logic or comparators are synthesised.

## Structure

- Package `fb_pattern_pkg`:
  - mode encodings: `PAT_SOLID`, `PAT_LBAR`, `PAT_CHECKER`, `PAT_GRID`
  - FSM state encodings
  - default resolution constants
- Sub-module `fb_pattern_word`: combinational word builder from (mode, xw, y). It contains the per-pixel mode logic and the border option. The top level owns the FSM, counters and output registers.

## Test plan

- **SOLID, `wr_ready`=1, defaults:** 24000 writes, addresses 0..23999 contiguous, all data 16'hFFFF; `done` pulses once, 24001 cycles after `start`; `busy` low afterwards.
- **LBAR:** addresses 0, 50, 100, ..., 23950 get 16'hFFFF; all others 16'h0000.
- **CHECKER, `CELL_LOG2`=4:**
  - addr 0 = 16'hFFFF, addr 1 = 16'h0000.
  - addr 800 (y=16, xw=0) = 16'h0000; addr 801 = 16'hFFFF.
- **GRID, `CELL_LOG2`=4:**
  - addr 0..49 = 16'hFFFF (y=0).
  - addr 50 (y=1) = 16'h8000.
  - addr 800 (y=16) = 16'hFFFF.
- **Backpressure and control:**
  - Pseudo-random `wr_ready`: the accepted address sequence is exactly 0..23999 and `wr_addr`/`wr_data` never change while stalled.
  - A `start` pulse mid-fill is ignored.
  - `reset` at addr 1000 drops `wr_en` on the next edge; a following `start` begins again at addr 0.
- **`FB_PATTERN_BORDER_EN` defined, LBAR:**
  - addr 1 = 16'hFFFF (top line).
  - addr 99 = 16'h0001 (x=799).
  - addr 51 = 16'h0000.
  - addr 23999 = 16'hFFFF (bottom line).
